id_inst_queue: RTL and testbench

- Parametrised instruction queue between IF and ID; decouples instruction-SRAM return data from decode-stage stalls.
- Every fetched {pc, inst} pair is captured the cycle it returns, so none is lost while ID is stalled.
- ID consumes from the head with a valid/ready handshake.
- Supports branch flush with optional delay-slot retention.

---
 rtl/id_inst_queue_pkg.sv | 22 ++
 rtl/id_inst_queue.sv | 119 +++++++++++
 tb/tb_id_inst_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/id_inst_queue_pkg.sv
// Shared constants and flush decoding for the IF->ID instruction queue.
// IQ_TO_ID_WD is the width of the {out_valid, out_pc, out_inst} bus that feeds ID.
package id_inst_queue_pkg;

  localparam int IQ_DEPTH    = 4;
  localparam int IQ_PC_W     = 32;
  localparam int IQ_INST_W   = 32;
  localparam int IQ_TO_ID_WD = IQ_PC_W + IQ_INST_W + 1;

  typedef enum logic [1:0] {
    FL_NONE,
    FL_ALL,
    FL_KEEP
  } flush_mode_e;

  // flush_keep has no meaning unless flush is also asserted.
  function automatic flush_mode_e flush_mode(input logic flush, input logic keep);
    if (!flush) return FL_NONE;
    return keep ? FL_KEEP : FL_ALL;
  endfunction

endpackage

// File: rtl/id_inst_queue.sv
// Instruction queue between IF and ID: captures every returning {pc, inst}
// so none is lost while decode stalls, with branch flush and delay-slot keep.
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int INST_W = IQ_INST_W,
  parameter int PC_W   = IQ_PC_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              flush_keep,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_next, wr_next;
  logic [PTR_W-1:0] rd_inc, wr_inc, surv_ptr;
  logic [CNT_W-1:0] count_next;
  logic             push, pop, wr_en, have_surv;
  flush_mode_e      mode;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign mode = flush_mode(flush, flush_keep);

  assign rd_inc = rd_ptr + 1'b1;
  assign wr_inc = wr_ptr + 1'b1;

  // Delay-slot survivor is the oldest entry still present once this cycle's pop is taken.
  assign surv_ptr  = pop ? rd_inc : rd_ptr;
  assign have_surv = pop ? (count >= CNT_W'(2)) : (count >= CNT_W'(1));

  always_comb begin
    wr_en      = push;
    rd_next    = pop  ? rd_inc : rd_ptr;
    wr_next    = push ? wr_inc : wr_ptr;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase

    case (mode)
      FL_ALL: begin
        wr_en      = 1'b0;
        rd_next    = wr_ptr;
        wr_next    = wr_ptr;
        count_next = '0;
      end
      FL_KEEP: begin
        wr_en   = 1'b0;
        wr_next = wr_ptr;
        if (have_surv) begin
          rd_next    = surv_ptr;
          wr_next    = surv_ptr + 1'b1;
          count_next = CNT_W'(1);
        end else if (push) begin
          // Delay slot arrives on the same cycle as the branch resolves.
          wr_en      = 1'b1;
          rd_next    = wr_ptr;
          wr_next    = wr_inc;
          count_next = CNT_W'(1);
        end else begin
          rd_next    = wr_ptr;
          count_next = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      count  <= count_next;
    end
  end

  // An empty queue presents all-zero inst, which decodes as a nop.
  assign out_pc   = empty ? '0 : pc_mem[rd_ptr];
  assign out_inst = empty ? '0 : inst_mem[rd_ptr];

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue (DEPTH=4): fill/drain, streaming wrap,
// flush with and without delay-slot retention, and reset mid-fill.
module tb_id_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush, flush_keep, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, out_valid, full, empty;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  id_inst_queue #(.DEPTH(4), .INST_W(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_keep(flush_keep),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic test_reset();
    rst = 1; flush = 0; flush_keep = 0; in_valid = 0; out_ready = 0;
    in_pc = '0; in_inst = '0;
    tick(); tick();
    rst = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b expected 0", full); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h expected 0", out_pc); end
    n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out_inst: got %h expected 0", out_inst); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    $display("reset done");
  endtask

  task automatic test_single();
    in_valid = 1; in_pc = 32'hBFC00000; in_inst = 32'h3C011234; out_ready = 1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0", out_valid); end
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL single_pc: got %h expected bfc00000", out_pc); end
    n_checks++; if (out_inst !== 32'h3C011234) begin n_fail++; $display("FAIL single_inst: got %h expected 3c011234", out_inst); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
    n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL single_nop: got %h expected 0", out_inst); end
    $display("single push/pop pc=bfc00000");
  endtask

  task automatic test_fill();
    logic [31:0] exp_pc;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_pc = 32'(i * 4); in_inst = inst_of(32'(i * 4));
      n_checks++; if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_in_ready_%0d: got %b expected %b", i, in_ready, (i < 4)); end
      tick();
      $display("push attempt pc=%h count=%0d", in_pc, count);
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    // Pop while full with a push offered: push must be refused.
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      n_checks++; if (out_pc !== exp_pc || out_inst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL fill_order_%0d: got %h/%h expected %h/%h", i, out_pc, out_inst, exp_pc, inst_of(exp_pc)); end
      $display("pop pc=%h", out_pc);
      tick();
      if (i == 0) begin
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fill_no_writethrough: got %0d expected 3", count); end
        in_valid = 0;
      end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained: got %b expected 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    out_ready = 0; in_valid = 1;
    in_pc = 32'h100; in_inst = inst_of(32'h100); tick();
    in_pc = 32'h104; in_inst = inst_of(32'h104); tick();
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      in_pc = 32'h108 + 32'(4 * k); in_inst = inst_of(in_pc);
      exp_pc = 32'h100 + 32'(4 * k);
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d expected 2", k, count); end
      n_checks++; if (out_pc !== exp_pc || out_inst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL b2b_order_%0d: got %h/%h expected %h/%h", k, out_pc, out_inst, exp_pc, inst_of(exp_pc)); end
      $display("push pc=%h pop pc=%h", in_pc, out_pc);
      tick();
    end
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      exp_pc = 32'h128 + 32'(4 * k);
      n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL b2b_drain_%0d: got %h expected %h", k, out_pc, exp_pc); end
      $display("pop pc=%h", out_pc);
      tick();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b expected 1", empty); end
  endtask

  task automatic test_flush_keep();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h10 + 32'(4 * i); in_inst = inst_of(in_pc); tick();
    end
    in_valid = 0; flush = 1; flush_keep = 1; out_ready = 1;
    $display("flush_keep with pop pc=%h", out_pc);
    tick();
    flush = 0; flush_keep = 0; out_ready = 0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL fk_count: got %0d expected 1", count); end
    n_checks++; if (out_pc !== 32'h14) begin n_fail++; $display("FAIL fk_pc: got %h expected 14", out_pc); end
    in_valid = 1; in_pc = 32'h30; in_inst = inst_of(32'h30); tick();
    in_valid = 0; out_ready = 1;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL fk_refill_count: got %0d expected 2", count); end
    tick();
    n_checks++; if (out_pc !== 32'h30) begin n_fail++; $display("FAIL fk_next_pc: got %h expected 30", out_pc); end
    $display("pop pc=%h", out_pc);
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fk_empty: got %b expected 1", empty); end
  endtask

  task automatic test_flush_late_slot();
    out_ready = 0; in_valid = 1; in_pc = 32'h20; in_inst = inst_of(32'h20); tick();
    flush = 1; flush_keep = 1; out_ready = 1;
    in_pc = 32'h24; in_inst = inst_of(32'h24);
    tick();
    flush = 0; flush_keep = 0; in_valid = 0; out_ready = 0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL late_count: got %0d expected 1", count); end
    n_checks++; if (out_pc !== 32'h24 || out_inst !== inst_of(32'h24)) begin n_fail++; $display("FAIL late_head: got %h/%h expected 24/%h", out_pc, out_inst, inst_of(32'h24)); end
    $display("late delay slot pc=%h", out_pc);
    // flush_keep alone is a plain push
    flush_keep = 1; in_valid = 1; in_pc = 32'h28; in_inst = inst_of(32'h28); tick();
    flush_keep = 0; in_valid = 0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL keep_alone_count: got %0d expected 2", count); end
    out_ready = 1; tick(); tick(); out_ready = 0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL late_drain: got %b expected 1", empty); end
  endtask

  task automatic test_flush_all_and_reset();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h30 + 32'(4 * i); in_inst = inst_of(in_pc); tick();
    end
    flush = 1; flush_keep = 0; in_pc = 32'h40; in_inst = inst_of(32'h40);
    tick();
    flush = 0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fa_empty: got %b expected 1", empty); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fa_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL fa_out_pc: got %h expected 0", out_pc); end
    $display("flush all done");
    in_pc = 32'h44; in_inst = inst_of(32'h44); tick();
    n_checks++; if (out_pc !== 32'h44) begin n_fail++; $display("FAIL fa_refill_pc: got %h expected 44", out_pc); end
    in_pc = 32'h48; in_inst = inst_of(32'h48); tick();
    rst = 1; out_ready = 1; flush = 1; flush_keep = 1;
    tick();
    rst = 0; in_valid = 0; out_ready = 0; flush = 0; flush_keep = 0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    $display("reset mid-fill done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush_keep();
    test_flush_late_slot();
    test_flush_all_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
